// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the MEM-stage data memory: bus defaults, FSM states and
// power-up content codes.
package data_mem_unit_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  localparam int INIT_ZERO  = 0;  // every word powers up as zero
  localparam int INIT_INDEX = 1;  // word[i] powers up as i

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_unit_mem_bank_be.sv
// DEPTH x DATA_W word array with per-byte write enables and a registered read port.
// Power-up contents come from INIT_MODE; a per-word flag selects stored vs initial data.
module mem_bank_be
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 256,
  parameter int INIT_MODE = INIT_ZERO,
  localparam int BYTES    = DATA_W / 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [BYTES-1:0]  be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  // NOTE: the array itself is never reset; only these power-up flags carry an initial
  // value, so a functional reset leaves committed writes intact.
  logic [DEPTH-1:0]  written_q = '0;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] lane_mask;

  always_comb begin
    init_word = (INIT_MODE == INIT_INDEX) ? DATA_W'(idx_i) : '0;
    cur_word  = written_q[idx_i] ? mem_q[idx_i] : init_word;
    lane_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_mask[8*b +: 8] = {8{be_i[b]}};
    end
  end

  // Lane merge starts from the current word so partial writes keep untouched bytes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i]     <= (cur_word & ~lane_mask) | (wdata_i & lane_mask);
      written_q[idx_i] <= 1'b1;
    end
    if (re_i) begin
      rdata_q <= cur_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory: valid/ready request channel, address checking, latency FSM and
// registered response; stall is fed back to the hazard logic.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter int INIT_MODE = INIT_ZERO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                stall
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               rd_ok_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [ADDR_W-1:0]  idx_full;
  logic               err_d;
  logic               accept;
  logic [DATA_W-1:0]  bank_rdata;

  assign idx_full  = req_addr >> OFF_W;
  assign err_d     = ((req_addr & ADDR_W'(BYTES - 1)) != '0) || ((idx_full >> IDX_W) != '0);
  assign req_ready = (state_q != S_BUSY);
  assign accept    = req_valid & req_ready & ~rst;
  assign stall     = req_valid & ~req_ready;

  mem_bank_be #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE)
  ) u_bank (
    .clk     (clk),
    .we_i    (accept & req_we & ~err_d),
    .re_i    (accept & ~req_we & ~err_d),
    .idx_i   (idx_full[IDX_W-1:0]),
    .be_i    (req_be),
    .wdata_i (req_wdata),
    .rdata_o (bank_rdata)
  );

  // RESP behaves like IDLE for acceptance, which gives back-to-back throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            err_q   <= err_d;
            rd_ok_q <= ~req_we & ~err_d;
            if (LATENCY > 1) begin
              state_q <= S_BUSY;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_d;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && rd_ok_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances (latency 1, 4 and 3 with index init) driven by
// a directed sequence; a reference memory feeds a per-instance scoreboard of responses.
module tb_data_mem_unit;

  localparam int NI = 3;
  localparam int LAT [NI]  = '{1, 4, 3};
  localparam int INIT [NI] = '{0, 0, 1};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [3:0]  req_be    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        stall     [NI];

  logic [31:0] mdl [NI][256];
  exp_t        sb  [NI][$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT[0]), .INIT_MODE(INIT[0])) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .stall(stall[0]));

  data_mem_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT[1]), .INIT_MODE(INIT[1])) u_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .stall(stall[1]));

  data_mem_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT[2]), .INIT_MODE(INIT[2])) u_l3 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_be(req_be[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .stall(stall[2]));

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int k, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_be[k]    = be;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
  endtask

  task automatic idle(int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
    req_be[k]    = '0;
    req_addr[k]  = '0;
    req_wdata[k] = '0;
  endtask

  // One clock: score accepted requests against the model, then check every response slot.
  task automatic tick();
    exp_t e;
    int   idx;
    for (int k = 0; k < NI; k++) begin
      if (!rst[k] && req_valid[k] && req_ready[k]) begin
        idx     = int'(req_addr[k] >> 2);
        e.err   = (req_addr[k][1:0] != 2'b00) || (idx >= 256);
        e.rdata = '0;
        e.due   = cyc + LAT[k];
        if (!e.err && req_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (req_be[k][b]) mdl[k][idx][8*b +: 8] = req_wdata[k][8*b +: 8];
        end else if (!e.err) begin
          e.rdata = mdl[k][idx];
        end
        sb[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) sb[k].delete();
      if (sb[k].size() != 0 && sb[k][0].due == cyc) begin
        e = sb[k].pop_front();
        check($sformatf("rsp_valid%0d", k), 64'(rsp_valid[k]), 64'(1));
        check($sformatf("rsp_rdata%0d", k), 64'(rsp_rdata[k]), 64'(e.rdata));
        check($sformatf("rsp_err%0d", k), 64'(rsp_err[k]), 64'(e.err));
      end else begin
        check($sformatf("rsp_quiet%0d", k), 64'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 64'(0));
      end
    end
  endtask

  task automatic wait_drained(int k, int budget);
    for (int i = 0; i < budget && sb[k].size() != 0; i++) tick();
    check($sformatf("drain_timeout%0d", k), 64'(sb[k].size()), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      idle(k);
      for (int i = 0; i < 256; i++) mdl[k][i] = (INIT[k] == 1) ? 32'(i) : 32'h0;
    end
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_ready%0d", k), 64'(req_ready[k]), 64'(1));
      check($sformatf("reset_stall%0d", k), 64'(stall[k]), 64'(0));
      rst[k] = 1'b0;
    end
    tick();

    // Latency 1: write then read back-to-back, ready never drops.
    drive(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    tick();
    check("t1_ready_w", 64'(req_ready[0]), 64'(1));
    drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
    tick();
    check("t1_rdata", 64'(rsp_rdata[0]), 64'hDEADBEEF);
    check("t1_ready_r", 64'(req_ready[0]), 64'(1));

    // Byte lanes, including an all-lanes-off write.
    drive(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    tick();
    drive(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    tick();
    drive(0, 1'b0, 4'h0, 32'h20, 32'h0);
    tick();
    check("t2_lanes", 64'(rsp_rdata[0]), 64'h11BB33DD);
    drive(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    tick();
    check("t2_be0_err", 64'(rsp_err[0]), 64'(0));
    drive(0, 1'b0, 4'h0, 32'h20, 32'h0);
    tick();
    check("t2_be0_keep", 64'(rsp_rdata[0]), 64'h11BB33DD);

    // Errors: misaligned read, out-of-range write that must not alias onto word 0.
    drive(0, 1'b0, 4'h0, 32'h13, 32'h0);
    tick();
    check("t4_misalign_err", 64'({rsp_valid[0], rsp_err[0], rsp_rdata[0]}), {30'h0, 2'b11, 32'h0});
    drive(0, 1'b1, 4'hF, 32'h400, 32'hFFFFFFFF);
    tick();
    check("t4_oob_err", 64'(rsp_err[0]), 64'(1));
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("t4_word0_intact", 64'(rsp_rdata[0]), 64'h0);
    idle(0);
    tick();

    // Latency 4: ready low for three cycles, second request taken on the response cycle.
    drive(1, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D);
    tick();
    idle(1);
    wait_drained(1, 8);
    drive(1, 1'b0, 4'h0, 32'h8, 32'h0);
    tick();
    drive(1, 1'b1, 4'hF, 32'hC, 32'h12345678);
    for (int j = 1; j <= 3; j++) begin
      check($sformatf("t3_ready_T%0d", j), 64'(req_ready[1]), 64'(0));
      check($sformatf("t3_stall_T%0d", j), 64'(stall[1]), 64'(1));
      tick();
    end
    check("t3_rsp_T4", 64'({rsp_valid[1], rsp_rdata[1]}), {31'h0, 1'b1, 32'hCAFEF00D});
    check("t3_ready_T4", 64'(req_ready[1]), 64'(1));
    check("t3_stall_T4", 64'(stall[1]), 64'(0));
    tick();
    idle(1);
    check("t3_second_busy", 64'(req_ready[1]), 64'(0));
    wait_drained(1, 8);
    drive(1, 1'b0, 4'h0, 32'hC, 32'h0);
    tick();
    idle(1);
    wait_drained(1, 8);

    // Latency 3 with index init: reset mid-read drops the response, keeps written data.
    drive(2, 1'b1, 4'hF, 32'h40, 32'h5A5A5A5A);
    tick();
    idle(2);
    wait_drained(2, 8);
    drive(2, 1'b0, 4'h0, 32'h40, 32'h0);
    tick();
    idle(2);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    check("t5_ready_after_rst", 64'(req_ready[2]), 64'(1));
    check("t5_no_rsp", 64'(rsp_valid[2]), 64'(0));
    repeat (4) tick();
    drive(2, 1'b0, 4'h0, 32'h40, 32'h0);
    tick();
    idle(2);
    tick();
    tick();
    check("t5_write_kept", 64'({rsp_valid[2], rsp_rdata[2]}), {31'h0, 1'b1, 32'h5A5A5A5A});

    // Reset beats a simultaneous request: the write must not land.
    rst[2] = 1'b1;
    drive(2, 1'b1, 4'hF, 32'h44, 32'hFFFFFFFF);
    tick();
    rst[2] = 1'b0;
    drive(2, 1'b0, 4'h0, 32'h44, 32'h0);
    tick();
    idle(2);
    tick();
    tick();
    check("t5_rst_wins", 64'(rsp_rdata[2]), 64'h11);

    // Power-up index contents on the last word.
    drive(2, 1'b0, 4'h0, 32'h3FC, 32'h0);
    tick();
    idle(2);
    tick();
    tick();
    check("t6_init_last", 64'(rsp_rdata[2]), 64'd255);
    tick();

    for (int k = 0; k < NI; k++) check($sformatf("final_drain%0d", k), 64'(sb[k].size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
